// File: rtl/sys_reg_rmw_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sys_reg_rmw_ctrl_pkg
// Shared definitions for the system-register read-modify-write controller:
// command codes, FSM state encoding, requester IDs and SR1 field positions.
// ----------------------------------------------------------------------------
package sys_reg_rmw_ctrl_pkg;

    localparam int CMD_W  = 5;
    localparam int DATA_W = 32;

    // System-register commands
    localparam logic [CMD_W-1:0] CMD_BUFFER0  = 5'd0;
    localparam logic [CMD_W-1:0] CMD_BUFFER1  = 5'd1;
    localparam logic [CMD_W-1:0] CMD_MMUMOD_R = 5'd2;
    localparam logic [CMD_W-1:0] CMD_IM_R     = 5'd3;
    localparam logic [CMD_W-1:0] CMD_CMOD_R   = 5'd4;
    localparam logic [CMD_W-1:0] CMD_MMUMOD_W = 5'd5;
    localparam logic [CMD_W-1:0] CMD_IM_W     = 5'd6;
    localparam logic [CMD_W-1:0] CMD_CMOD_W   = 5'd7;

    // SR1 field bit positions
    localparam int SR1_MMUMOD_LSB = 0;
    localparam int SR1_MMUMOD_MSB = 1;
    localparam int SR1_IM_BIT     = 2;
    localparam int SR1_CMOD_LSB   = 5;
    localparam int SR1_CMOD_MSB   = 6;

    // Owner of an operation
    localparam logic ID_EXC = 1'b0;
    localparam logic ID_EXE = 1'b1;

    // Number of back-to-back EXC grants (while EXE waits) before EXE wins
    localparam logic [1:0] STREAK_LIMIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sys_reg_field_unit.sv
// ----------------------------------------------------------------------------
// sys_reg_field_unit
// Purely combinational SR1 field read/modify function.
//   sr1      : current SR1 contents
//   operand  : write operand of the granted request
//   cmd      : granted command
//   result   : value returned to the requester
//   sr1_we   : 1 when the command updates SR1 (only the *_W commands)
//   sr1_new  : the SR1 value to store when sr1_we is set
// ----------------------------------------------------------------------------
module sys_reg_field_unit
    import sys_reg_rmw_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] sr1,
    input  logic [DATA_W-1:0] operand,
    input  logic [CMD_W-1:0]  cmd,
    output logic [DATA_W-1:0] result,
    output logic              sr1_we,
    output logic [DATA_W-1:0] sr1_new
);

    always_comb begin
        result  = sr1;
        sr1_we  = 1'b0;
        sr1_new = sr1;
        case (cmd)
            CMD_BUFFER0:  result = sr1;
            CMD_BUFFER1:  result = operand;
            CMD_MMUMOD_R: result = {30'h0, sr1[SR1_MMUMOD_MSB:SR1_MMUMOD_LSB]};
            CMD_IM_R:     result = {31'h0, sr1[SR1_IM_BIT]};
            CMD_CMOD_R:   result = {30'h0, sr1[SR1_CMOD_MSB:SR1_CMOD_LSB]};
            CMD_MMUMOD_W: begin
                sr1_new[SR1_MMUMOD_MSB:SR1_MMUMOD_LSB] = operand[1:0];
                sr1_we = 1'b1;
                result = sr1_new;
            end
            CMD_IM_W: begin
                sr1_new[SR1_IM_BIT] = operand[0];
                sr1_we = 1'b1;
                result = sr1_new;
            end
            CMD_CMOD_W: begin
                sr1_new[SR1_CMOD_MSB:SR1_CMOD_LSB] = operand[1:0];
                sr1_we = 1'b1;
                result = sr1_new;
            end
            default: result = sr1;  // unknown codes read back SR1, no write
        endcase
    end

endmodule

// File: rtl/sys_reg_rmw_ctrl.sv
// ----------------------------------------------------------------------------
// sys_reg_rmw_ctrl
// Arbitrates between the exception unit (EXC) and the execute stage (EXE)
// for read-modify-write access to system register SR1.
//   iCLOCK / iRESET_SYNC      : clock, synchronous active-high reset
//   iEXC_REQ/CMD/DATA, oEXC_ACK : exception-unit request port
//   iEXE_REQ/CMD/DATA, oEXE_ACK : execute-stage request port
//   oRESULT_VALID/ID/DATA     : one-cycle completion pulse, owner, result
//   oSR1                      : current SR1 contents
//   oBUSY                     : controller not idle
// Timing: ACK in IDLE (T), compute in EXEC (T+1), result valid in DONE (T+2).
// ----------------------------------------------------------------------------
module sys_reg_rmw_ctrl
    import sys_reg_rmw_ctrl_pkg::*;
#(
    parameter logic [31:0] P_SR1_INIT = 32'h0000_0000
)(
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iEXC_REQ,
    input  logic [4:0]  iEXC_CMD,
    input  logic [31:0] iEXC_DATA,
    output logic        oEXC_ACK,
    input  logic        iEXE_REQ,
    input  logic [4:0]  iEXE_CMD,
    input  logic [31:0] iEXE_DATA,
    output logic        oEXE_ACK,
    output logic        oRESULT_VALID,
    output logic        oRESULT_ID,
    output logic [31:0] oRESULT_DATA,
    output logic [31:0] oSR1,
    output logic        oBUSY
);

    state_t       state_reg, state_next;
    logic [4:0]   cmd_reg;
    logic [31:0]  data_reg;
    logic         id_reg;
    logic [31:0]  sr1_reg;
    logic [31:0]  result_data_reg;
    logic         result_id_reg;
    logic [1:0]   streak_reg;

    logic         exe_wins;
    logic         grant_exc;
    logic         grant_exe;
    logic [31:0]  fu_result;
    logic         fu_sr1_we;
    logic [31:0]  fu_sr1_new;

    // EXE wins when EXC is silent, or when EXC has already won STREAK_LIMIT
    // grants in a row while EXE was waiting.
    assign exe_wins = iEXE_REQ && (!iEXC_REQ || (streak_reg == STREAK_LIMIT));

    always_comb begin
        state_next = state_reg;
        grant_exc  = 1'b0;
        grant_exe  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (iEXC_REQ || iEXE_REQ) begin
                    state_next = ST_EXEC;
                    if (exe_wins) begin
                        grant_exe = 1'b1;
                    end else begin
                        grant_exc = 1'b1;
                    end
                end
            end
            ST_EXEC: state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    sys_reg_field_unit u_field_unit (
        .sr1     (sr1_reg),
        .operand (data_reg),
        .cmd     (cmd_reg),
        .result  (fu_result),
        .sr1_we  (fu_sr1_we),
        .sr1_new (fu_sr1_new)
    );

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_reg       <= ST_IDLE;
            cmd_reg         <= '0;
            data_reg        <= '0;
            id_reg          <= 1'b0;
            sr1_reg         <= P_SR1_INIT;
            result_data_reg <= '0;
            result_id_reg   <= 1'b0;
            streak_reg      <= '0;
        end else begin
            state_reg <= state_next;

            if (state_reg == ST_IDLE) begin
                if (grant_exc) begin
                    cmd_reg  <= iEXC_CMD;
                    data_reg <= iEXC_DATA;
                    id_reg   <= ID_EXC;
                end else if (grant_exe) begin
                    cmd_reg  <= iEXE_CMD;
                    data_reg <= iEXE_DATA;
                    id_reg   <= ID_EXE;
                end

                // Streak only counts EXC wins that made EXE wait.
                if (!iEXE_REQ || grant_exe) begin
                    streak_reg <= '0;
                end else if (grant_exc) begin
                    streak_reg <= streak_reg + 2'd1;
                end
            end

            if (state_reg == ST_EXEC) begin
                if (fu_sr1_we) begin
                    sr1_reg <= fu_sr1_new;
                end
                result_data_reg <= fu_result;
                result_id_reg   <= id_reg;
            end
        end
    end

    // Handshake/status outputs are forced low during reset.
    assign oEXC_ACK      = grant_exc && !iRESET_SYNC;
    assign oEXE_ACK      = grant_exe && !iRESET_SYNC;
    assign oRESULT_VALID = (state_reg == ST_DONE) && !iRESET_SYNC;
    assign oBUSY         = (state_reg != ST_IDLE) && !iRESET_SYNC;
    assign oRESULT_ID    = result_id_reg;
    assign oRESULT_DATA  = result_data_reg;
    assign oSR1          = sr1_reg;

endmodule

// File: tb/tb_sys_reg_rmw_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sys_reg_rmw_ctrl
// Directed, table-driven bench for sys_reg_rmw_ctrl (P_SR1_INIT = 32'h61).
// Inputs change on the falling edge; outputs are checked just after it.
// ----------------------------------------------------------------------------
module tb_sys_reg_rmw_ctrl;

    localparam logic [31:0] INIT = 32'h0000_0061;

    logic        clk = 1'b0;
    logic        srst;
    logic        exc_req, exe_req;
    logic [4:0]  exc_cmd, exe_cmd;
    logic [31:0] exc_data, exe_data;
    logic        exc_ack, exe_ack;
    logic        res_valid, res_id;
    logic [31:0] res_data, sr1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sys_reg_rmw_ctrl #(.P_SR1_INIT(INIT)) dut (
        .iCLOCK        (clk),
        .iRESET_SYNC   (srst),
        .iEXC_REQ      (exc_req),
        .iEXC_CMD      (exc_cmd),
        .iEXC_DATA     (exc_data),
        .oEXC_ACK      (exc_ack),
        .iEXE_REQ      (exe_req),
        .iEXE_CMD      (exe_cmd),
        .iEXE_DATA     (exe_data),
        .oEXE_ACK      (exe_ack),
        .oRESULT_VALID (res_valid),
        .oRESULT_ID    (res_id),
        .oRESULT_DATA  (res_data),
        .oSR1          (sr1),
        .oBUSY         (busy)
    );

    typedef struct {
        logic        id;
        logic [4:0]  cmd;
        logic [31:0] data;
        logic [31:0] exp_res;
        logic [31:0] exp_sr1;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One single-requester transaction with full timing checks.
    task automatic run_op(input int idx, input logic id, input logic [4:0] cmd,
                          input logic [31:0] d, input logic [31:0] exp_res,
                          input logic [31:0] exp_sr1);
        logic acked;
        acked = 1'b0;
        @(negedge clk);
        if (id) begin
            exe_req = 1'b1; exe_cmd = cmd; exe_data = d;
        end else begin
            exc_req = 1'b1; exc_cmd = cmd; exc_data = d;
        end
        #1;
        // Controller is idle here, so the ACK must come in this same cycle.
        acked = id ? exe_ack : exc_ack;
        chk("ack_at_T", {31'h0, acked}, 32'h1);
        chk("other_ack_at_T", {31'h0, id ? exc_ack : exe_ack}, 32'h0);
        @(posedge clk); #1;
        exc_req = 1'b0; exe_req = 1'b0;
        @(negedge clk); #1;  // T+1
        chk("valid_T1", {31'h0, res_valid}, 32'h0);
        chk("busy_T1", {31'h0, busy}, 32'h1);
        @(negedge clk); #1;  // T+2
        chk("valid_T2", {31'h0, res_valid}, 32'h1);
        chk("id_T2", {31'h0, res_id}, {31'h0, id});
        chk("data_T2", res_data, exp_res);
        chk("sr1_T2", sr1, exp_sr1);
        @(negedge clk); #1;  // T+3: back in IDLE, result held
        chk("valid_T3", {31'h0, res_valid}, 32'h0);
        chk("data_hold_T3", res_data, exp_res);
        chk("busy_T3", {31'h0, busy}, 32'h0);
        $display("op %0d: id=%0d cmd=%h data=%h -> result=%h sr1=%h", idx, id, cmd, d, res_data, sr1);
    endtask

    initial begin
        logic        grant_id[6];
        int          grant_cyc[6];
        int          ngrant;
        logic        exp_gid[6];

        // {id, cmd, operand, expected result, expected SR1 afterwards}
        vecs[0]  = '{1'b0, 5'd4,  32'h0000_0000, 32'h0000_0003, 32'h0000_0061}; // CMOD_R after reset
        vecs[1]  = '{1'b1, 5'd0,  32'h1234_5678, 32'h0000_0061, 32'h0000_0061}; // BUFFER0
        vecs[2]  = '{1'b0, 5'd1,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0061}; // BUFFER1
        vecs[3]  = '{1'b1, 5'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0061}; // MMUMOD_R
        vecs[4]  = '{1'b0, 5'd3,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0061}; // IM_R
        vecs[5]  = '{1'b0, 5'h1F, 32'hFFFF_FFFF, 32'h0000_0061, 32'h0000_0061}; // unknown cmd
        vecs[6]  = '{1'b0, 5'd5,  32'h0000_0000, 32'h0000_0060, 32'h0000_0060}; // MMUMOD_W 0
        vecs[7]  = '{1'b0, 5'd7,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000}; // CMOD_W 0
        vecs[8]  = '{1'b1, 5'd6,  32'h0000_0001, 32'h0000_0004, 32'h0000_0004}; // IM_W 1 on SR1=0
        vecs[9]  = '{1'b0, 5'd7,  32'hFFFF_FFFE, 32'h0000_0044, 32'h0000_0044}; // CMOD_W 2
        vecs[10] = '{1'b1, 5'd3,  32'h0000_0000, 32'h0000_0001, 32'h0000_0044}; // IM_R
        vecs[11] = '{1'b0, 5'd4,  32'h0000_0000, 32'h0000_0002, 32'h0000_0044}; // CMOD_R
        vecs[12] = '{1'b0, 5'd5,  32'h0000_0002, 32'h0000_0046, 32'h0000_0046}; // MMUMOD_W 2
        vecs[13] = '{1'b0, 5'd6,  32'hFFFF_FFFE, 32'h0000_0042, 32'h0000_0042}; // IM_W 0
        vecs[14] = '{1'b1, 5'h08, 32'h0000_0000, 32'h0000_0042, 32'h0000_0042}; // unknown cmd

        exp_gid = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        srst = 1'b1;
        exc_req = 1'b1; exc_cmd = 5'd0; exc_data = '0;
        exe_req = 1'b1; exe_cmd = 5'd0; exe_data = '0;

        // Reset with requests pending: no ACK, not busy, SR1 = init.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_exc_ack", {31'h0, exc_ack}, 32'h0);
        chk("rst_exe_ack", {31'h0, exe_ack}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_valid", {31'h0, res_valid}, 32'h0);
        chk("rst_sr1", sr1, INIT);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_res_id", {31'h0, res_id}, 32'h0);
        $display("reset: sr1=%h busy=%0d", sr1, busy);
        exc_req = 1'b0; exe_req = 1'b0;
        @(negedge clk);
        srst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(i, vecs[i].id, vecs[i].cmd, vecs[i].data, vecs[i].exp_res, vecs[i].exp_sr1);
        end

        // Continuous simultaneous requests: EXC, EXC, EXE repeating, 3 cycles apart.
        @(negedge clk);
        exc_req = 1'b1; exc_cmd = 5'd0; exc_data = 32'h1;
        exe_req = 1'b1; exe_cmd = 5'd1; exe_data = 32'h2;
        ngrant = 0;
        for (int cyc = 0; cyc < 40 && ngrant < 6; cyc++) begin
            #1;
            if (exc_ack && exe_ack) begin
                checks++; errors++;
                $display("FAIL arb_dual_ack: got both acks at cycle %0d expected one", cyc);
            end
            if (exc_ack || exe_ack) begin
                grant_id[ngrant]  = exe_ack;
                grant_cyc[ngrant] = cyc;
                ngrant++;
            end
            if (ngrant < 6) @(negedge clk);
        end
        @(posedge clk); #1;
        exc_req = 1'b0; exe_req = 1'b0;
        chk("arb_grant_count", ngrant, 6);
        for (int g = 0; g < ngrant; g++) begin
            chk("arb_grant_id", {31'h0, grant_id[g]}, {31'h0, exp_gid[g]});
            if (g > 0) chk("arb_grant_gap", grant_cyc[g] - grant_cyc[g-1], 3);
            $display("arb grant %0d: id=%0d cycle=%0d", g, grant_id[g], grant_cyc[g]);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("arb_idle_busy", {31'h0, busy}, 32'h0);

        // Reset during EXEC of MMUMOD_W D=3: operation aborted.
        @(negedge clk);
        exc_req = 1'b1; exc_cmd = 5'd5; exc_data = 32'h3;
        #1;
        chk("abort_ack", {31'h0, exc_ack}, 32'h1);
        @(posedge clk); #1;
        exc_req = 1'b0;
        @(negedge clk);            // EXEC
        srst = 1'b1;
        #1;
        chk("abort_busy_in_rst", {31'h0, busy}, 32'h0);
        chk("abort_valid_in_rst", {31'h0, res_valid}, 32'h0);
        @(negedge clk);            // first IDLE cycle after reset
        srst = 1'b0;
        exc_req = 1'b1; exc_cmd = 5'd1; exc_data = 32'h0000_1234;
        #1;
        chk("abort_valid_after", {31'h0, res_valid}, 32'h0);
        chk("abort_sr1", sr1, INIT);
        chk("abort_next_ack", {31'h0, exc_ack}, 32'h1);
        $display("abort: sr1=%h next_ack=%0d", sr1, exc_ack);
        @(posedge clk); #1;
        exc_req = 1'b0;
        @(negedge clk); #1;
        chk("abort_next_valid_T1", {31'h0, res_valid}, 32'h0);
        @(negedge clk); #1;
        chk("abort_next_valid_T2", {31'h0, res_valid}, 32'h1);
        chk("abort_next_data", res_data, 32'h0000_1234);
        chk("abort_next_sr1", sr1, INIT);
        $display("post-abort op: result=%h sr1=%h", res_data, sr1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_reg_rmw_ctrl.md
SYS_REG_RMW_CTRL -- requirements
Module: sys_reg_rmw_ctrl

Interface
REQ-001 SHALL have parameter P_SR1_INIT, default 32'h0000_0000, the SR1 value loaded at reset.
REQ-002 SHALL have port iCLOCK  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port iRESET_SYNC  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port iEXC_REQ  in  1  exception-unit request, held until acked.
REQ-005 SHALL have port iEXC_CMD  in  5  exception-unit system-register command.
REQ-006 SHALL have port iEXC_DATA  in  32  exception-unit write operand.
REQ-007 SHALL have port oEXC_ACK  out  1  one-cycle accept pulse to the exception unit.
REQ-008 SHALL have ports iEXE_REQ, iEXE_CMD, iEXE_DATA and oEXE_ACK, same widths and meanings, for the execute stage.
REQ-009 SHALL have port oRESULT_VALID  out  1  one-cycle completion pulse.
REQ-010 SHALL have port oRESULT_ID  out  1  owner of the completed operation: 0=EXC, 1=EXE.
REQ-011 SHALL have port oRESULT_DATA  out  32  result of the completed operation.
REQ-012 SHALL have port oSR1  out  32  current SR1 contents.
REQ-013 SHALL have port oBUSY  out  1  high whenever the state is not IDLE.

Function
REQ-014 Commands SHALL be: BUFFER0=0, BUFFER1=1, MMUMOD_R=2, IM_R=3, CMOD_R=4, MMUMOD_W=5, IM_W=6, CMOD_W=7.
REQ-015 Field results with S=SR1 and D=operand SHALL be: BUFFER0 -> S; BUFFER1 -> D; MMUMOD_R -> {30'h0,S[1:0]}; IM_R -> {31'h0,S[2]}; CMOD_R -> {30'h0,S[6:5]}.
REQ-016 Write results SHALL be: MMUMOD_W -> {S[31:2],D[1:0]}; IM_W -> {S[31:3],D[0],S[1:0]}; CMOD_W -> {S[31:7],D[1:0],S[4:0]}.
REQ-017 Only the *_W commands SHALL update SR1; all other commands leave SR1 unchanged.
REQ-018 Any other command code SHALL produce result S and SHALL leave SR1 unchanged.
REQ-019 The FSM SHALL have the states IDLE, EXEC and DONE, with the transitions IDLE->EXEC on grant, EXEC->DONE always, and DONE->IDLE always.
REQ-020 In IDLE with any request pending, the controller SHALL assert exactly one ACK combinationally in that cycle (T) and latch the granted CMD, DATA and ID.
REQ-021 The result SHALL be computed in EXEC (T+1); SR1 and oRESULT_DATA SHALL be registered at the end of T+1.
REQ-022 In DONE (T+2), oRESULT_VALID SHALL be 1 and oSR1 SHALL already show the new value; the earliest next ACK SHALL be at T+3.
REQ-023 Arbitration SHALL normally give EXC priority over EXE.
REQ-024 A 2-bit EXC streak counter SHALL increment on each EXC grant made while EXE is requesting.
REQ-025 When the streak counter equals 2 and EXE is requesting, EXE SHALL win the grant.
REQ-026 The streak counter SHALL clear on every EXE grant and whenever iEXE_REQ is low during IDLE.
REQ-027 No ACK SHALL be asserted outside IDLE; a request arriving in EXEC or DONE SHALL wait.
REQ-028 oRESULT_DATA and oRESULT_ID SHALL hold their values until the next completion.

Reset
REQ-029 On iRESET_SYNC=1 at a clock edge, the controller SHALL enter IDLE, load SR1=P_SR1_INIT and clear the streak counter, oRESULT_DATA, oRESULT_ID and all latched request fields to 0.
REQ-030 While reset is asserted, oEXC_ACK, oEXE_ACK, oRESULT_VALID and oBUSY SHALL be 0.
REQ-031 Reset in EXEC or DONE SHALL abort the operation without an SR1 write and without a result pulse.

Structure
REQ-032 The command codes, state encodings and SR1 field bit positions SHALL be defined in the shared core package/header.
REQ-033 The field function of REQ-015..018 SHALL be a separate combinational sub-module, sys_reg_field_unit, instantiated once.

Verification
REQ-034 Reset with P_SR1_INIT=32'h0000_0061 -> oSR1=32'h61, oBUSY=0, no ACK, and a CMOD_R request afterwards returns 32'h3.
REQ-035 EXE issues IM_W with D=1 on SR1=0 -> ACK at T, oRESULT_VALID at T+2 with ID=1, data 32'h4 and oSR1=32'h4.
REQ-036 EXC and EXE request simultaneously and continuously -> grants EXC, EXC, EXE, EXC, EXC, EXE, with ACKs 3 cycles apart.
REQ-037 Command 5'h1F with D=32'hFFFF_FFFF -> result equals the prior SR1 and SR1 is unchanged.
REQ-038 Assert reset during EXEC of MMUMOD_W with D=3 -> no oRESULT_VALID, oSR1=P_SR1_INIT, and the next request is acked in the first IDLE cycle.
